cache_key_cam_ctrl: RTL and testbench
=====================================

# cache_key_cam_ctrl

Parametrised key-lookup CAM with in-band configuration for the cache datapath. It captures single-beat configuration packets from the control AXI-Stream, then writes or deletes ternary entries in an internal register-based CAM. It answers fully pipelined key lookups with a fixed two-cycle latency, and resolves multiple hits to the lowest address. It sits between the key extractor (lookup side) and the host control channel (configuration side).

## Interface
- C_AXIS_DATA_WIDTH, 256: control stream data width.
- C_AXIS_TUSER_WIDTH, 128: control stream tuser width; tuser is ignored.
- KEY_WIDTH, 32: key and mask width.
- DEPTH, 32: number of entries; power of two, 2..256.
- ADDR_W, $clog2(DEPTH): entry address width.
- KEY_OFFSET, 88: LSB of the key field in tdata.
- MASK_OFFSET, 120: LSB of the mask field in tdata; a mask bit of 1 means don't-care.
- ADDR_OFFSET, 152: LSB of the address field in tdata.
- OP_BIT, 160: tdata bit holding the opcode (0 = write, 1 = delete).
- AUTO_ADDR, 0: 1 = ignore the address field and use the internal write pointer.
- axis_clk  in  1  the single clock.
- aresetn  in  1  asynchronous, active-low reset.
- ctrl_s_axis_tdata  in  C_AXIS_DATA_WIDTH  configuration beat.
- ctrl_s_axis_tuser  in  C_AXIS_TUSER_WIDTH  unused.
- ctrl_s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  unused.
- ctrl_s_axis_tvalid  in  1  beat valid.
- ctrl_s_axis_tlast  in  1  last beat.
- ctrl_s_axis_tready  out  1  tied to 1; the block never stalls.
- i_key  in  KEY_WIDTH  lookup key.
- i_key_valid  in  1  lookup request; one request per cycle is accepted.
- o_lookup_valid  out  1  result strobe.
- o_lookup_hit  out  1  at least one entry matched.
- o_lookup_addr  out  ADDR_W  lowest matching address; 0 on a miss.
- o_entry_count  out  ADDR_W+1  number of valid entries.
- o_cfg_drop  out  1  one-cycle pulse when a packet is discarded.

## Operation
- Configuration FSM states:
  - IDLE, on a valid beat with tlast: latch the beat (CAPTURE) and stay in IDLE.
  - IDLE, on a valid beat without tlast: go to FLUSH and pulse o_cfg_drop.
  - FLUSH: discard beats until a valid beat with tlast, then return to IDLE.
- Commit: a latched beat is applied to the table on the next edge.
  - Write: store key and mask at the address, set the entry's valid bit.
  - Delete: clear the entry's valid bit.
- Address: when AUTO_ADDR=1, the write pointer is used and advances after each write, wrapping DEPTH-1 -> 0; deletes use the address field. When AUTO_ADDR=0, the address is taken from tdata[ADDR_OFFSET +: ADDR_W].
- Match rule: entry i matches when it is valid and ((i_key ^ key_i) & ~mask_i) == 0.
- Entry count:
  - A write to an invalid entry adds 1.
  - A delete of a valid entry subtracts 1.
  - Overwriting a valid entry or deleting an invalid one leaves the count unchanged.
  - The count saturates at DEPTH.
- Lookup pipeline:
  - Stage 0 registers the key and a valid flag.
  - Stage 1 compares against all entries, priority-encodes the result and registers it.

## Timing
- Reset (async): all entries invalid; key/mask registers 0; FSM to IDLE; write pointer 0; all outputs 0 (o_lookup_addr = 0, o_entry_count = 0).
- A key presented in cycle N produces its result in cycle N+2. Throughput is 1 key per cycle.
- A configuration beat in cycle N is committed at the end of cycle N+1.
  - A lookup whose compare cycle is N+1 or earlier sees the old table.
  - A lookup whose compare cycle is N+2 or later sees the new table.
- A write and a lookup in the same cycle are both served; neither blocks the other.
- Reset asserted mid-packet: the FSM returns to IDLE; the remaining beats of the aborted packet are treated as new packets.

## Configuration
- CACHE_CAM_DELETE_EN defined: OP_BIT is decoded and the delete opcode is honoured.
- CACHE_CAM_DELETE_EN undefined: OP_BIT is ignored, every captured beat is a write, and entries can only be cleared by reset.

## Test plan
- Reset, then write key 0x11223344 with mask 0 to address 5; look up 0x11223344 -> two cycles later o_lookup_valid=1, hit=1, addr=5; o_entry_count=1.
- Write entry 3 = 0xAB000000 with mask 0x00FFFFFF and entry 7 = 0xAB12CD34 with mask 0; look up 0xAB12CD34 -> hit=1, addr=3 (lowest address wins).
- Send a 3-beat packet -> o_cfg_drop pulses once and the table is unchanged; a following single-beat write is committed normally.
- With AUTO_ADDR=1, send DEPTH+1 writes -> the last one lands at address 0 and o_entry_count = DEPTH.
- With CACHE_CAM_DELETE_EN defined, delete address 5 -> the next lookup of 0x11223344 returns hit=0, addr=0, and the count drops by 1. With the macro undefined, the same beat overwrites address 5.
- Present a key in the same cycle as a config beat that writes a matching entry -> miss. The same key presented 2 cycles later -> hit.

Source files
------------

// File: rtl/cache_key_cam_ctrl_if.sv
// Control-stream and lookup bundle for cache_key_cam_ctrl.
// Master drives configuration beats and keys; slave is the CAM controller.
interface cache_key_cam_ctrl_if #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int KEY_WIDTH          = 32,
    parameter int ADDR_W             = 5
);
    logic [C_AXIS_DATA_WIDTH-1:0]   ctrl_s_axis_tdata;
    logic [C_AXIS_TUSER_WIDTH-1:0]  ctrl_s_axis_tuser;
    logic [C_AXIS_DATA_WIDTH/8-1:0] ctrl_s_axis_tkeep;
    logic                           ctrl_s_axis_tvalid;
    logic                           ctrl_s_axis_tlast;
    logic                           ctrl_s_axis_tready;
    logic [KEY_WIDTH-1:0]           i_key;
    logic                           i_key_valid;
    logic                           o_lookup_valid;
    logic                           o_lookup_hit;
    logic [ADDR_W-1:0]              o_lookup_addr;
    logic [ADDR_W:0]                o_entry_count;
    logic                           o_cfg_drop;

    modport master (
        output ctrl_s_axis_tdata, ctrl_s_axis_tuser, ctrl_s_axis_tkeep,
               ctrl_s_axis_tvalid, ctrl_s_axis_tlast, i_key, i_key_valid,
        input  ctrl_s_axis_tready, o_lookup_valid, o_lookup_hit,
               o_lookup_addr, o_entry_count, o_cfg_drop
    );

    modport slave (
        input  ctrl_s_axis_tdata, ctrl_s_axis_tuser, ctrl_s_axis_tkeep,
               ctrl_s_axis_tvalid, ctrl_s_axis_tlast, i_key, i_key_valid,
        output ctrl_s_axis_tready, o_lookup_valid, o_lookup_hit,
               o_lookup_addr, o_entry_count, o_cfg_drop
    );
endinterface

// File: rtl/cache_key_cam_ctrl.sv
// Ternary key CAM with single-beat in-band configuration and a 2-cycle lookup pipe.
// Optional macro CACHE_CAM_DELETE_EN enables the delete opcode on OP_BIT.
module cache_key_cam_ctrl #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int KEY_WIDTH          = 32,
    parameter int DEPTH              = 32,
    parameter int ADDR_W             = $clog2(DEPTH),
    parameter int KEY_OFFSET         = 88,
    parameter int MASK_OFFSET        = 120,
    parameter int ADDR_OFFSET        = 152,
    parameter int OP_BIT             = 160,
    parameter int AUTO_ADDR          = 0
) (
    input logic                 axis_clk,
    input logic                 aresetn,
    cache_key_cam_ctrl_if.slave bus
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [0:0]           state_q, state_d;
    logic                 cap_d, drop_d, drop_q;
    logic                 cap_valid_q, cap_del_q;
    logic [KEY_WIDTH-1:0] cap_key_q, cap_mask_q;
    logic [ADDR_W-1:0]    cap_addr_q, cap_addr_d;
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic                 beat_del;

    logic [KEY_WIDTH-1:0] key_q  [DEPTH];
    logic [KEY_WIDTH-1:0] mask_q [DEPTH];
    logic [DEPTH-1:0]     vld_q;
    logic [ADDR_W:0]      cnt_q, cnt_d;

    logic [KEY_WIDTH-1:0] s0_key_q;
    logic                 s0_vld_q;
    logic [DEPTH-1:0]     match;
    logic                 hit_d;
    logic [ADDR_W-1:0]    addr_d;
    logic                 res_vld_q, res_hit_q;
    logic [ADDR_W-1:0]    res_addr_q;

`ifdef CACHE_CAM_DELETE_EN
    assign beat_del = bus.ctrl_s_axis_tdata[OP_BIT];
`else
    assign beat_del = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cap_d   = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ctrl_s_axis_tvalid) begin
                    if (bus.ctrl_s_axis_tlast) begin
                        cap_d = 1'b1;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (bus.ctrl_s_axis_tvalid && bus.ctrl_s_axis_tlast) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Auto-addressed writes claim the pointer at capture; deletes always use the field.
    always_comb begin
        cap_addr_d = bus.ctrl_s_axis_tdata[ADDR_OFFSET +: ADDR_W];
        wr_ptr_d   = wr_ptr_q;
        if ((AUTO_ADDR != 0) && !beat_del) begin
            cap_addr_d = wr_ptr_q;
            if (cap_d) wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cap_valid_q) begin
            if (cap_del_q) begin
                if (vld_q[cap_addr_q] && (cnt_q != '0)) cnt_d = cnt_q - CNT_ONE;
            end else if (!vld_q[cap_addr_q] && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = vld_q[i] && (((s0_key_q ^ key_q[i]) & ~mask_q[i]) == '0);
        end
    end

    always_comb begin
        hit_d  = s0_vld_q && (|match);
        addr_d = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (s0_vld_q && match[i]) addr_d = ADDR_W'(i);
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            drop_q      <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_del_q   <= 1'b0;
            cap_key_q   <= '0;
            cap_mask_q  <= '0;
            cap_addr_q  <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            cap_valid_q <= cap_d;
            wr_ptr_q    <= wr_ptr_d;
            if (cap_d) begin
                cap_del_q  <= beat_del;
                cap_key_q  <= bus.ctrl_s_axis_tdata[KEY_OFFSET +: KEY_WIDTH];
                cap_mask_q <= bus.ctrl_s_axis_tdata[MASK_OFFSET +: KEY_WIDTH];
                cap_addr_q <= cap_addr_d;
            end
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i]  <= '0;
                mask_q[i] <= '0;
            end
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (cap_valid_q) begin
                if (cap_del_q) begin
                    vld_q[cap_addr_q] <= 1'b0;
                end else begin
                    key_q[cap_addr_q]  <= cap_key_q;
                    mask_q[cap_addr_q] <= cap_mask_q;
                    vld_q[cap_addr_q]  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            s0_key_q   <= '0;
            s0_vld_q   <= 1'b0;
            res_vld_q  <= 1'b0;
            res_hit_q  <= 1'b0;
            res_addr_q <= '0;
        end else begin
            s0_key_q   <= bus.i_key;
            s0_vld_q   <= bus.i_key_valid;
            res_vld_q  <= s0_vld_q;
            res_hit_q  <= hit_d;
            res_addr_q <= addr_d;
        end
    end

    assign bus.ctrl_s_axis_tready = 1'b1;
    assign bus.o_lookup_valid     = res_vld_q;
    assign bus.o_lookup_hit       = res_hit_q;
    assign bus.o_lookup_addr      = res_addr_q;
    assign bus.o_entry_count      = cnt_q;
    assign bus.o_cfg_drop         = drop_q;
endmodule

// File: tb/tb_cache_key_cam_ctrl.sv
// Directed-vector bench for cache_key_cam_ctrl: main instance (DEPTH 32, explicit
// addressing) plus a small auto-addressed instance (DEPTH 4).
module tb_cache_key_cam_ctrl;
`ifdef CACHE_CAM_DELETE_EN
    localparam bit DEL_EN = 1'b1;
`else
    localparam bit DEL_EN = 1'b0;
`endif

    logic clk;
    logic aresetn;
    int   n_vec;
    int   n_bad;

    cache_key_cam_ctrl_if #(.ADDR_W(5)) bm ();
    cache_key_cam_ctrl_if #(.ADDR_W(2)) ba ();

    cache_key_cam_ctrl #(.DEPTH(32), .AUTO_ADDR(0)) dut_main (
        .axis_clk(clk), .aresetn(aresetn), .bus(bm.slave)
    );
    cache_key_cam_ctrl #(.DEPTH(4), .AUTO_ADDR(1)) dut_auto (
        .axis_clk(clk), .aresetn(aresetn), .bus(ba.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          do_cfg;
        bit          del;
        logic [31:0] key;
        logic [31:0] mask;
        logic [7:0]  addr;
        logic [31:0] lk;
        bit          exp_hit;
        logic [4:0]  exp_addr;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_beat(input bit del, input logic [31:0] key,
                                             input logic [31:0] mask, input logic [7:0] addr);
        logic [255:0] d;
        d = '0;
        d[88 +: 32]  = key;
        d[120 +: 32] = mask;
        d[152 +: 8]  = addr;
        d[160]       = del;
        return d;
    endfunction

    task automatic beat_m(input bit v, input bit last, input bit del, input logic [31:0] key,
                          input logic [31:0] mask, input logic [7:0] addr);
        bm.ctrl_s_axis_tdata  = mk_beat(del, key, mask, addr);
        bm.ctrl_s_axis_tvalid = v;
        bm.ctrl_s_axis_tlast  = last;
    endtask

    task automatic look_m(input string nm, input logic [31:0] k, input bit eh,
                          input logic [4:0] ea, input int ec);
        bm.i_key       = k;
        bm.i_key_valid = 1'b1;
        tick();
        bm.i_key_valid = 1'b0;
        tick();
        chk({nm, ".valid"}, 64'(bm.o_lookup_valid), 64'(1));
        chk({nm, ".hit"},   64'(bm.o_lookup_hit),   64'(eh));
        chk({nm, ".addr"},  64'(bm.o_lookup_addr),  64'(ea));
        chk({nm, ".count"}, 64'(bm.o_entry_count),  64'(ec));
    endtask

    task automatic look_a(input string nm, input logic [31:0] k, input bit eh,
                          input logic [1:0] ea, input int ec);
        ba.i_key       = k;
        ba.i_key_valid = 1'b1;
        tick();
        ba.i_key_valid = 1'b0;
        tick();
        chk({nm, ".valid"}, 64'(ba.o_lookup_valid), 64'(1));
        chk({nm, ".hit"},   64'(ba.o_lookup_hit),   64'(eh));
        chk({nm, ".addr"},  64'(ba.o_lookup_addr),  64'(ea));
        chk({nm, ".count"}, 64'(ba.o_entry_count),  64'(ec));
    endtask

    initial begin
        int c9;
        int drops;
        n_vec = 0;
        n_bad = 0;
        c9    = DEL_EN ? 3 : 5;

        //           cfg del key           mask          addr lookup        hit addr count
        vecs[0]  = '{0, 0, 32'h0,        32'h0,        8'd0,  32'h11223344, 0, 5'd0,  0};
        vecs[1]  = '{1, 0, 32'h11223344, 32'h0,        8'd5,  32'h11223344, 1, 5'd5,  1};
        vecs[2]  = '{1, 0, 32'hAB000000, 32'h00FFFFFF, 8'd3,  32'hAB999999, 1, 5'd3,  2};
        vecs[3]  = '{1, 0, 32'hAB12CD34, 32'h0,        8'd7,  32'hAB12CD34, 1, 5'd3,  3};
        vecs[4]  = '{0, 0, 32'h0,        32'h0,        8'd0,  32'hAC12CD34, 0, 5'd0,  3};
        vecs[5]  = '{1, 0, 32'h55555555, 32'h0,        8'd7,  32'h55555555, 1, 5'd7,  3};
        vecs[6]  = '{1, 1, 32'h99999999, 32'h0,        8'd5,  32'h11223344, 0, 5'd0,  DEL_EN ? 2 : 3};
        vecs[7]  = '{0, 0, 32'h0,        32'h0,        8'd0,  32'h99999999, !DEL_EN,
                     DEL_EN ? 5'd0 : 5'd5, DEL_EN ? 2 : 3};
        vecs[8]  = '{1, 1, 32'h66666666, 32'h0,        8'd9,  32'h66666666, !DEL_EN,
                     DEL_EN ? 5'd0 : 5'd9, DEL_EN ? 2 : 4};
        vecs[9]  = '{1, 0, 32'h0,        32'hFFFFFFFF, 8'd31, 32'h12345678, 1, 5'd31, c9};
        vecs[10] = '{0, 0, 32'h0,        32'h0,        8'd0,  32'hAB12CD34, 1, 5'd3,  c9};

        clk     = 1'b0;
        aresetn = 1'b0;
        beat_m(0, 0, 0, 0, 0, 0);
        bm.ctrl_s_axis_tuser = '0;
        bm.ctrl_s_axis_tkeep = '0;
        bm.i_key             = '0;
        bm.i_key_valid       = 1'b0;
        ba.ctrl_s_axis_tdata  = '0;
        ba.ctrl_s_axis_tuser  = '0;
        ba.ctrl_s_axis_tkeep  = '0;
        ba.ctrl_s_axis_tvalid = 1'b0;
        ba.ctrl_s_axis_tlast  = 1'b0;
        ba.i_key              = '0;
        ba.i_key_valid        = 1'b0;
        #23;
        chk("rst.valid", 64'(bm.o_lookup_valid), 64'(0));
        chk("rst.hit",   64'(bm.o_lookup_hit),   64'(0));
        chk("rst.addr",  64'(bm.o_lookup_addr),  64'(0));
        chk("rst.count", 64'(bm.o_entry_count),  64'(0));
        chk("rst.drop",  64'(bm.o_cfg_drop),     64'(0));
        chk("rst.ready", 64'(bm.ctrl_s_axis_tready), 64'(1));
        aresetn = 1'b1;
        tick();

        for (int v = 0; v < 11; v++) begin
            if (vecs[v].do_cfg) begin
                beat_m(1, 1, vecs[v].del, vecs[v].key, vecs[v].mask, vecs[v].addr);
                tick();
                beat_m(0, 0, 0, 0, 0, 0);
                tick();
            end
            look_m($sformatf("vec%0d", v), vecs[v].lk, vecs[v].exp_hit,
                   vecs[v].exp_addr, vecs[v].exp_cnt);
        end

        // Multi-beat packet is discarded with a single drop pulse.
        drops = 0;
        beat_m(1, 0, 0, 32'h77777777, 0, 10); tick(); drops += int'(bm.o_cfg_drop);
        beat_m(1, 0, 0, 32'h77777777, 0, 10); tick(); drops += int'(bm.o_cfg_drop);
        beat_m(1, 1, 0, 32'h77777777, 0, 10); tick(); drops += int'(bm.o_cfg_drop);
        beat_m(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            drops += int'(bm.o_cfg_drop);
        end
        chk("drop.pulses", 64'(drops), 64'(1));
        look_m("drop.unchanged", 32'h77777777, 1, 5'd31, c9);
        beat_m(1, 1, 0, 32'h77777777, 0, 10); tick();
        beat_m(0, 0, 0, 0, 0, 0); tick();
        look_m("drop.after", 32'h77777777, 1, 5'd10, c9 + 1);

        // Lookup racing a write: old table, then new table from the next key on.
        beat_m(1, 1, 0, 32'h0BADF00D, 0, 2);
        bm.i_key       = 32'h0BADF00D;
        bm.i_key_valid = 1'b1;
        tick();
        beat_m(0, 0, 0, 0, 0, 0);
        tick();
        chk("race.old.valid", 64'(bm.o_lookup_valid), 64'(1));
        chk("race.old.addr",  64'(bm.o_lookup_addr),  64'(31));
        tick();
        bm.i_key_valid = 1'b0;
        chk("race.n1.hit",  64'(bm.o_lookup_hit),  64'(1));
        chk("race.n1.addr", 64'(bm.o_lookup_addr), 64'(2));
        tick();
        chk("race.n2.valid", 64'(bm.o_lookup_valid), 64'(1));
        chk("race.n2.addr",  64'(bm.o_lookup_addr),  64'(2));
        chk("race.count",    64'(bm.o_entry_count),  64'(c9 + 2));
        tick();
        chk("race.idle.valid", 64'(bm.o_lookup_valid), 64'(0));

        // Reset while flushing: the next single beat is a fresh packet.
        beat_m(1, 0, 0, 32'h2468ACE0, 0, 6);
        tick();
        beat_m(0, 0, 0, 0, 0, 0);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mrst.count", 64'(bm.o_entry_count), 64'(0));
        chk("mrst.drop",  64'(bm.o_cfg_drop),    64'(0));
        #4;
        aresetn = 1'b1;
        tick();
        beat_m(1, 1, 0, 32'h13579BDF, 0, 4); tick();
        beat_m(0, 0, 0, 0, 0, 0); tick();
        look_m("mrst.new", 32'h13579BDF, 1, 5'd4, 1);
        look_m("mrst.gone", 32'h0BADF00D, 0, 5'd0, 1);

        // Auto-addressed instance: DEPTH+1 writes wrap onto entry 0.
        for (int i = 0; i < 5; i++) begin
            ba.ctrl_s_axis_tdata  = mk_beat(0, 32'h100 + 32'(i), 32'h0, 8'd3);
            ba.ctrl_s_axis_tvalid = 1'b1;
            ba.ctrl_s_axis_tlast  = 1'b1;
            tick();
        end
        ba.ctrl_s_axis_tvalid = 1'b0;
        ba.ctrl_s_axis_tlast  = 1'b0;
        tick();
        look_a("auto.wrap",  32'h104, 1, 2'd0, 4);
        look_a("auto.old0",  32'h100, 0, 2'd0, 4);
        look_a("auto.e1",    32'h101, 1, 2'd1, 4);
        look_a("auto.e3",    32'h103, 1, 2'd3, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
